down_counter_timer: RTL
=======================

Name: down_counter_timer

Overview:
- Loadable, enable-gated down-counter with terminal-count (underflow) pulse.
- Counterpart of the team's 8-bit up-counter with overflow flag: that block counts up and flags wrap. This block counts down from a programmed value and flags when it reaches zero.
- Used as a programmable interval timer / event-count-down in the same clock domain. Its `en` can be driven by the up-counter's `ovf` to cascade.

Parameters:
- WIDTH, 8, bit width of `count`, `load_val` and the internal reload register.
- PRESCALE, 4, enabled-cycle divisor. Used only when DOWN_COUNTER_PRESCALE_EN is defined. Legal range is 2 or greater.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- en  input  1  count enable; a count tick occurs on each rising clk edge with en=1.
- load  input  1  synchronous load strobe; priority over en.
- load_val  input  WIDTH  start/reload value, sampled when load=1.
- auto_reload  input  1  on terminal tick: 1 means reload and keep running, 0 means stop.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE (one-shot expired); level, not a pulse.
- uf  output  1  one-cycle registered pulse on each terminal tick.

Behaviour:
- Reset (async, rst=1) clears:
  - count=0, busy=0, done=0, uf=0.
  - reload register=0, state=IDLE.
  - prescaler (if present)=0.
  - Release is synchronous-safe; the first action occurs on the first rising edge with rst=0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Outputs are registered. uf defaults to 0 every cycle unless set by a terminal tick.
- load=1 (any state), applied next edge:
  - count←load_val and reload←load_val.
  - The prescaler is cleared.
  - If load_val≠0, state←RUN. If load_val=0, state←IDLE.
  - uf stays 0 on a load edge.
- load=1 together with en=1: load wins and no decrement happens on that edge.
- RUN, tick, count>1: count←count−1.
- RUN, tick, count=1 (terminal tick): uf←1, then:
  - auto_reload=1: count←reload, stay RUN.
  - auto_reload=0: count←0, state←DONE.
  - auto_reload is sampled only on the terminal tick edge.
- Period: a load of N (N≥1) gives exactly N ticks between the load edge and the first uf pulse. With auto_reload, uf repeats every N ticks.
- RUN with no tick (en=0): all state holds.
- IDLE and DONE: en is ignored and count holds. Leave only by load.
- Arithmetic: count never wraps below 0. Maximum load value is 2^WIDTH−1, loaded without truncation.
- A reset asserted mid-RUN clears immediately. No uf is generated and the reload value is lost.

Optional Feature:
- Macro DOWN_COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler of ceil(log2(PRESCALE)) bits counts cycles with en=1, modulo PRESCALE.
  - tick = en AND (prescaler = PRESCALE−1).
  - The prescaler runs only in RUN and is cleared by load and rst.
  - The period becomes N·PRESCALE enabled cycles.
- Not defined: tick = en, no prescaler logic, and PRESCALE is unused.

Test Plan:
1. Assert rst for 100 ns with clk period 10 ns, en=0 → count=0, busy=0, done=0, uf=0 throughout. Asserting rst mid-cycle clears outputs before the next edge.
2. load_val=5, load pulse, then en=1, auto_reload=0 → count 5,4,3,2,1,0 on successive edges; uf=1 exactly on the edge where count→0; then busy=0, done=1, and count stays 0 with en held high.
3. load_val=3, auto_reload=1, en=1 → count 3,2,1,3,2,1,3…; uf pulses every 3rd cycle; busy stays 1 and done stays 0.
4. load_val=8, en toggled 1,0,1,0 → count decrements only on en=1 edges. In RUN at count=4, assert load with load_val=2 and en=1 → count=2 next edge with no decrement and no uf.
5. In RUN at count=3, assert rst asynchronously → count=0, busy=0 immediately, and no uf. Then load_val=0 → stays IDLE with busy=0 and done=0.
6. With DOWN_COUNTER_PRESCALE_EN defined and PRESCALE=4: load_val=2, en=1 continuously → count 2→1 after 4 cycles, 1→0 after 8 cycles, and uf pulses at cycle 8.

Source files
------------

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable, enable-gated down-counter with a one-cycle
// terminal-count pulse (uf), one-shot or auto-reload operation.
// Optional build macro DOWN_COUNTER_PRESCALE_EN inserts a modulo-PRESCALE
// prescaler so that only every PRESCALE-th enabled cycle counts as a tick.
module down_counter_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             uf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, reload_nxt, count_nxt;
  logic             uf_nxt, busy_nxt, done_nxt;
  logic             tick;

  // Reject an illegal divisor at elaboration time.
  if (PRESCALE < 2) begin : g_prescale_check
    $error("down_counter_timer: PRESCALE must be 2 or greater");
  end

`ifdef DOWN_COUNTER_PRESCALE_EN
  localparam int            PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre, pre_nxt;

  assign tick = en && (pre == PRE_LAST);

  // Prescaler next value: cleared by load, advances on enabled cycles in RUN only.
  always_comb begin
    pre_nxt = pre;
    if (load) begin
      pre_nxt = '0;
    end else if ((state == RUN) && en) begin
      pre_nxt = (pre == PRE_LAST) ? '0 : pre + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre <= '0;
    else     pre <= pre_nxt;
  end
`else
  assign tick = en;
`endif

  // Next-state and next-output decode: load has priority, then ticks in RUN.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    uf_nxt     = 1'b0;
    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = (load_val != '0) ? RUN : IDLE;
    end else if ((state == RUN) && tick) begin
      if (count > WIDTH'(1)) begin
        count_nxt = count - WIDTH'(1);
      end else begin
        // Terminal tick: count is 1 here, so the counter never wraps below 0.
        uf_nxt = 1'b1;
        if (auto_reload) begin
          count_nxt = reload;
        end else begin
          count_nxt = '0;
          state_nxt = DONE;
        end
      end
    end
    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

  // State and registered outputs; async reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      uf     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      uf     <= uf_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

endmodule
